ps2_kbmat: RTL and testbench
============================

// Module: ps2_kbmat
// PURPOSE
//  Upstream feeder of the blink keyboard input. Receives PS/2 set-2 scan codes
//  from a host keyboard, tracks make/break per key and drives the 64-bit Z88
//  key matrix image kbmat consumed by blink (bit = 8*col + row, col n = CPU
//  address line A(8+n), bit 1 = key held). Also flags protocol errors.
// PARAMETERS
//  FILT     4     mck cycles ps2_clk must be stable before an edge is accepted
//  TIMEOUT  1024  mck cycles without a ps2_clk fall mid-frame before the frame is aborted
// PORTS
//  mck      in   1   9.83MHz master clock, sole clock domain
//  rin_n    in   1   reset, asynchronous assert, active-low
//  ps2_clk  in   1   PS/2 clock from keyboard, asynchronous
//  ps2_dat  in   1   PS/2 data from keyboard, asynchronous
//  kb_clr   in   1   sync pulse: release all keys (focus loss, reset of host)
//  kbmat    out  64  key matrix image, 1 = pressed
//  key_evt  out  1   1-cycle pulse when any kbmat bit changes
//  rx_err   out  1   1-cycle pulse on parity/start/stop error or timeout
// BEHAVIOUR
//  Reset: kbmat=0, key_evt=0, rx_err=0, RX FSM=IDLE, decode FSM=NORM, sync FFs=1.
//  Input path: 2-FF synchroniser on both lines; filtered clk changes only after
//   FILT consecutive equal samples; a falling edge of filtered clk samples
//   synchronised ps2_dat.
//  RX FSM: IDLE -(fall, dat=0)-> DATA(8 bits, LSB first) -> PAR -> STOP -> IDLE.
//   IDLE fall with dat=1: ignored, no error. Parity odd over data+parity bit.
//   Bad parity or stop=0: frame discarded, rx_err pulses at STOP edge +1.
//   Timeout counter resets on every accepted fall; reaching TIMEOUT-1 in
//   DATA/PAR/STOP -> IDLE, rx_err pulse, partial byte discarded. Counter
//   saturates in IDLE (no wrap).
//  Byte strobe: valid byte presented to decoder 1 cycle after the stop edge;
//   kbmat updated the following cycle (stop edge +2 mck); key_evt same cycle.
//  Decode FSM (one byte per strobe):
//   NORM:  F0->BRK; E0->EXT; E1->SKIP(7); AA/FA/EE/FE->stay, ignored;
//          00/FF (overrun)->kbmat=0; other->press(code).
//   BRK:   code->release(code), ->NORM.   EXT: F0->EXTBRK; code->press(E0,code), ->NORM.
//   EXTBRK: code->release(E0,code), ->NORM.  SKIP(n): count down, ->NORM at 0.
//   Any unexpected prefix (E0/F0 in BRK/EXT/EXTBRK) restarts from that prefix.
//  Keymap: internal case table (code,ext)->{valid, idx[5:0]}; unmapped codes
//   change nothing and give no key_evt. Fixed entries include:
//   1C(A)->idx 33, 1B(S)->idx 35, 5A(ENTER)->idx 6, 12(LSHIFT)->idx 54,
//   59(RSHIFT)->idx 63, 76(ESC)->idx 61, E0 75(UP)->idx 11, E0 72(DOWN)->idx 10.
//  Two PS/2 keys may map to one bit: bit = OR of holders (per-source held
//   bits kept internally, kbmat bit = OR), so releasing one leaves bit set.
//  press of already-held key (typematic repeat): no change, no key_evt.
//  kb_clr: clears all held state next cycle; wins over a same-cycle byte
//   strobe (that byte's press/release is dropped; decode FSM still advances).
//  rx_err does not alter kbmat or decode state except timeout, which also
//   returns decode FSM to NORM.
//  Async reset mid-frame: everything to reset values; first frame after
//   release must start with a clean start bit.
// TESTING
//  1 Frame 1C (A make), FILT edges @ 12.5kHz -> kbmat[33]=1 at stop+2 mck, key_evt 1 pulse.
//  2 F0 1C after T1 -> kbmat[33]=0, key_evt; repeat 1C x5 while held -> one key_evt only.
//  3 E0 75 then E0 F0 75 -> kbmat[11] set then clear; plain 75 (KP8) unmapped -> no change.
//  4 1C with parity flipped -> rx_err pulse, kbmat unchanged; next good 1B -> kbmat[35]=1.
//  5 Stop clocking after 4 data bits for 1100 mck -> rx_err, then full frame 5A -> kbmat[6]=1.
//  6 Hold 12+59, send FF -> kbmat=0; hold 1C, assert kb_clr same cycle as 1B strobe -> kbmat=0.

Source files
------------

// File: rtl/ps2_kbmat.sv
// PS/2 set-2 keyboard receiver and scan-code decoder driving the Z88 key matrix image.
// Held state is kept per PS/2 key; a kbmat bit is the OR of every key mapped onto it.
module ps2_kbmat #(
  parameter int unsigned FILT    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        kb_clr,
  output logic [63:0] kbmat,
  output logic        key_evt,
  output logic        rx_err
);
  localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned NK = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_t;
  typedef enum logic [2:0] {D_NORM, D_BRK, D_EXT, D_EXTBRK, D_SKIP} dec_t;

  logic [1:0]    clk_sy, dat_sy;
  logic          fclk, fall, dat_s;
  logic [FW-1:0] fcnt;
  rx_t           rx_st, rx_nx;
  logic [2:0]    bcnt;
  logic [7:0]    sr, rx_byte;
  logic          par, byte_stb;
  logic [TW-1:0] tcnt;
  logic          tmo, shift_en, par_en, frame_end, frame_ok;
  dec_t          dst, dnx;
  logic [2:0]    skip;
  logic          act_press, act_rel, act_ovr, act_ext;
  logic [4:0]    km;
  logic [NK-1:0] held, held_nx;
  logic [63:0]   mat_nx;

  // {valid, key id} for each mapped (extended, code) pair
  function automatic logic [4:0] key_lookup(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h01C:  return {1'b1, 4'd0};
      9'h01B:  return {1'b1, 4'd1};
      9'h05A:  return {1'b1, 4'd2};
      9'h15A:  return {1'b1, 4'd3};
      9'h012:  return {1'b1, 4'd4};
      9'h059:  return {1'b1, 4'd5};
      9'h076:  return {1'b1, 4'd6};
      9'h175:  return {1'b1, 4'd7};
      9'h172:  return {1'b1, 4'd8};
      9'h16B:  return {1'b1, 4'd9};
      9'h174:  return {1'b1, 4'd10};
      9'h029:  return {1'b1, 4'd11};
      9'h066:  return {1'b1, 4'd12};
      9'h171:  return {1'b1, 4'd13};
      9'h00D:  return {1'b1, 4'd14};
      9'h015:  return {1'b1, 4'd15};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [5:0] key_bit(input logic [3:0] id);
    case (id)
      4'd0:    return 6'd33;
      4'd1:    return 6'd35;
      4'd2:    return 6'd6;
      4'd3:    return 6'd6;
      4'd4:    return 6'd54;
      4'd5:    return 6'd63;
      4'd6:    return 6'd61;
      4'd7:    return 6'd11;
      4'd8:    return 6'd10;
      4'd9:    return 6'd12;
      4'd10:   return 6'd13;
      4'd11:   return 6'd53;
      4'd12:   return 6'd7;
      4'd13:   return 6'd7;
      4'd14:   return 6'd60;
      default: return 6'd37;
    endcase
  endfunction

  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) begin
      clk_sy <= 2'b11;
      dat_sy <= 2'b11;
    end else begin
      clk_sy <= {clk_sy[0], ps2_clk};
      dat_sy <= {dat_sy[0], ps2_dat};
    end

  assign dat_s = dat_sy[1];
  // the FILT-th consecutive low sample is the accepted falling edge
  assign fall  = fclk && !clk_sy[1] && (fcnt == FW'(FILT - 1));

  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) begin
      fclk <= 1'b1;
      fcnt <= '0;
    end else if (clk_sy[1] == fclk) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT - 1)) begin
      fclk <= clk_sy[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end

  assign tmo = (rx_st != RX_IDLE) && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) rx_st <= RX_IDLE;
    else        rx_st <= rx_nx;

  always_comb begin
    rx_nx = rx_st;
    if (tmo) rx_nx = RX_IDLE;
    else if (fall)
      case (rx_st)
        RX_IDLE: if (!dat_s) rx_nx = RX_DATA;
        RX_DATA: if (bcnt == 3'd7) rx_nx = RX_PAR;
        RX_PAR:  rx_nx = RX_STOP;
        default: rx_nx = RX_IDLE;
      endcase
  end

  always_comb begin
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_end = 1'b0;
    if (fall && !tmo)
      case (rx_st)
        RX_DATA: shift_en  = 1'b1;
        RX_PAR:  par_en    = 1'b1;
        RX_STOP: frame_end = 1'b1;
        default: ;
      endcase
  end

  assign frame_ok = frame_end && dat_s && (^{sr, par});

  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) begin
      sr       <= '0;
      par      <= 1'b0;
      bcnt     <= '0;
      tcnt     <= '0;
      rx_byte  <= '0;
      byte_stb <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      if (shift_en) begin
        sr   <= {dat_s, sr[7:1]};
        bcnt <= bcnt + 3'd1;
      end else if (rx_st == RX_IDLE) begin
        bcnt <= '0;
      end
      if (par_en) par <= dat_s;
      if (fall) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT - 1)) tcnt <= tcnt + TW'(1);
      byte_stb <= frame_ok;
      if (frame_ok) rx_byte <= sr;
      rx_err   <= tmo || (frame_end && !frame_ok);
    end

  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) begin
      dst  <= D_NORM;
      skip <= '0;
    end else begin
      dst <= dnx;
      if (byte_stb && dst == D_NORM && rx_byte == 8'hE1) skip <= 3'd7;
      else if (byte_stb && dst == D_SKIP)                 skip <= skip - 3'd1;
    end

  always_comb begin
    dnx = dst;
    if (tmo) dnx = D_NORM;
    else if (byte_stb)
      case (dst)
        D_NORM:
          case (rx_byte)
            8'hF0:   dnx = D_BRK;
            8'hE0:   dnx = D_EXT;
            8'hE1:   dnx = D_SKIP;
            default: ;
          endcase
        D_EXT:
          if (rx_byte == 8'hF0)      dnx = D_EXTBRK;
          else if (rx_byte == 8'hE0) dnx = D_EXT;
          else                       dnx = D_NORM;
        D_BRK, D_EXTBRK:
          if (rx_byte == 8'hF0)      dnx = D_BRK;
          else if (rx_byte == 8'hE0) dnx = D_EXT;
          else                       dnx = D_NORM;
        D_SKIP:  if (skip == 3'd1) dnx = D_NORM;
        default: dnx = D_NORM;
      endcase
  end

  always_comb begin
    act_press = 1'b0;
    act_rel   = 1'b0;
    act_ovr   = 1'b0;
    act_ext   = 1'b0;
    if (byte_stb && rx_byte != 8'hF0 && rx_byte != 8'hE0)
      case (dst)
        D_NORM:
          case (rx_byte)
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
            8'h00, 8'hFF: act_ovr   = 1'b1;
            default:      act_press = 1'b1;
          endcase
        D_BRK:    act_rel = 1'b1;
        D_EXT:    begin act_press = 1'b1; act_ext = 1'b1; end
        D_EXTBRK: begin act_rel   = 1'b1; act_ext = 1'b1; end
        default: ;
      endcase
  end

  assign km = key_lookup(act_ext, rx_byte);

  always_comb begin
    held_nx = held;
    if (kb_clr || act_ovr)        held_nx = '0;
    else if (km[4] && act_press)  held_nx[km[3:0]] = 1'b1;
    else if (km[4] && act_rel)    held_nx[km[3:0]] = 1'b0;
  end

  always_comb begin
    mat_nx = '0;
    for (int unsigned i = 0; i < NK; i++)
      if (held_nx[i]) mat_nx[key_bit(4'(i))] = 1'b1;
  end

  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) begin
      held    <= '0;
      kbmat   <= '0;
      key_evt <= 1'b0;
    end else begin
      held    <= held_nx;
      kbmat   <= mat_nx;
      key_evt <= (mat_nx != kbmat);
    end

endmodule

// File: tb/tb_ps2_kbmat.sv
// Bench for ps2_kbmat: directed scenarios plus randomized key traffic against a
// behavioural model of the scan-code rules, checked every cycle.
module tb_ps2_kbmat;
  localparam int unsigned FILT    = 4;
  localparam int unsigned TIMEOUT = 1024;
  // PS/2 line edge -> 2 sync stages -> FILT samples -> accepted edge; kbmat follows 2 cycles later
  localparam int unsigned LAT     = FILT + 3;
  localparam int unsigned H       = 12;
  localparam int unsigned H_SLOW  = 393;

  logic        mck = 1'b0;
  logic        rin_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        kb_clr = 1'b0;
  logic [63:0] kbmat;
  logic        key_evt, rx_err;

  ps2_kbmat #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .mck(mck), .rin_n(rin_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .kb_clr(kb_clr), .kbmat(kbmat), .key_evt(key_evt), .rx_err(rx_err)
  );

  always #5 mck = ~mck;

  int unsigned cyc = 0;
  always @(posedge mck) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int evt_cnt = 0;

  logic [8:0] km_key [16] = '{9'h01C, 9'h01B, 9'h05A, 9'h15A, 9'h012, 9'h059, 9'h076, 9'h175,
                              9'h172, 9'h16B, 9'h174, 9'h029, 9'h066, 9'h171, 9'h00D, 9'h015};
  int         km_idx [16] = '{33, 35, 6, 6, 54, 63, 61, 11, 10, 12, 13, 53, 7, 7, 60, 37};
  logic [7:0] specials [9] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1, 8'hE0, 8'hF0, 8'h00, 8'hFF};

  int   mapidx [512];
  bit   held_k [512];
  bit   m_ext, m_brk;
  int   m_skip;

  logic [63:0] exp_mat = '0;
  logic        chk_en = 1'b0, err_win = 1'b0;
  logic        pm_v = 1'b0, pe_v = 1'b0;
  int unsigned pm_cyc, pe_cyc;
  logic [63:0] pm_mat;
  logic        e_evt, e_err;
  logic [7:0]  q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_n(input int unsigned n);
    repeat (n) @(negedge mck);
  endtask

  task automatic clear_held();
    for (int k = 0; k < 512; k++) held_k[k] = 1'b0;
  endtask

  function automatic logic [63:0] model_mat();
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 512; k++)
      if (held_k[k] && mapidx[k] >= 0) m[mapidx[k]] = 1'b1;
    return m;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit clr);
    bit norm;
    norm = !m_ext && !m_brk;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hF0) begin m_ext = m_ext && !m_brk; m_brk = 1'b1; end
    else if (b == 8'hE0) begin m_ext = 1'b1; m_brk = 1'b0; end
    else if (norm && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin end
    else if (norm && b == 8'hE1) m_skip = 7;
    else if (norm && (b == 8'h00 || b == 8'hFF)) clear_held();
    else begin
      if (!clr) held_k[{m_ext, b}] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    if (clr) clear_held();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int unsigned h,
                            input bit glitch, input bit clr_strobe);
    logic [10:0] bits;
    int unsigned c;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      if (glitch && i == 5) begin
        wait_n(2); ps2_clk = 1'b0; wait_n(FILT - 1); ps2_clk = 1'b1; wait_n(h - FILT - 1);
      end else begin
        wait_n(h);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        c = cyc;
        if (bad_par) begin
          pe_v = 1'b1; pe_cyc = c + FILT + 2;
        end else begin
          model_byte(b, clr_strobe);
          pm_v = 1'b1; pm_cyc = c + LAT; pm_mat = model_mat();
        end
      end
      if (i == 10 && clr_strobe) begin
        wait_n(FILT + 2); kb_clr = 1'b1; wait_n(1); kb_clr = 1'b0; wait_n(h - FILT - 3);
      end else begin
        wait_n(h);
      end
      ps2_clk = 1'b1;
    end
    wait_n(LAT + 4);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, H, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int unsigned nb, input int unsigned h, output int unsigned c_last);
    c_last = 0;
    for (int unsigned i = 0; i < nb; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wait_n(h); ps2_clk = 1'b0; c_last = cyc; wait_n(h); ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic pulse_clr();
    kb_clr = 1'b1;
    clear_held();
    pm_v = 1'b1; pm_cyc = cyc + 1; pm_mat = model_mat();
    wait_n(1);
    kb_clr = 1'b0;
    wait_n(3);
  endtask

  initial forever begin
    @(posedge mck);
    #1;
    if (chk_en) begin
      e_evt = 1'b0;
      e_err = 1'b0;
      if (pm_v && cyc == pm_cyc) begin
        e_evt = (pm_mat != exp_mat);
        exp_mat = pm_mat;
        pm_v = 1'b0;
      end
      if (pe_v && cyc == pe_cyc) begin
        e_err = 1'b1;
        pe_v = 1'b0;
      end
      if (key_evt) evt_cnt++;
      chk("kbmat", kbmat, exp_mat);
      chk("key_evt", 64'(key_evt), 64'(e_evt));
      if (!err_win) chk("rx_err", 64'(rx_err), 64'(e_err));
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned c4, t_err;
    int n_err, e0, r, k;
    bit ext, brk;
    logic [7:0] code;

    for (int i = 0; i < 512; i++) mapidx[i] = -1;
    for (int i = 0; i < 16; i++) mapidx[km_key[i]] = km_idx[i];
    clear_held();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;

    wait_n(4);
    chk("reset_kbmat", kbmat, 64'd0);
    chk("reset_key_evt", 64'(key_evt), 64'd0);
    chk("reset_rx_err", 64'(rx_err), 64'd0);
    rin_n = 1'b1;
    wait_n(2);
    chk_en = 1'b1;

    // A make at 12.5 kHz
    send_frame(8'h1C, 1'b0, H_SLOW, 1'b0, 1'b0);
    chk("t1_a_make", kbmat, 64'd1 << 33);

    // A break, then typematic repeats give a single event
    send_ok(8'hF0); send_ok(8'h1C);
    chk("t2_a_break", kbmat, 64'd0);
    e0 = evt_cnt;
    repeat (5) send_ok(8'h1C);
    chk("t2_repeat_evts", 64'(evt_cnt - e0), 64'd1);
    chk("t2_repeat_held", kbmat, 64'd1 << 33);
    send_ok(8'hF0); send_ok(8'h1C);

    // extended UP make/break, plain 75 unmapped
    send_ok(8'hE0); send_ok(8'h75);
    chk("t3_up_make", kbmat, 64'd1 << 11);
    send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
    chk("t3_up_break", kbmat, 64'd0);
    e0 = evt_cnt;
    send_ok(8'h75);
    chk("t3_kp8_nochange", kbmat, 64'd0);
    chk("t3_kp8_noevt", 64'(evt_cnt - e0), 64'd0);

    // parity error then a good frame
    send_frame(8'h1C, 1'b1, H, 1'b0, 1'b0);
    chk("t4_bad_par_kbmat", kbmat, 64'd0);
    send_ok(8'h1B);
    chk("t4_s_make", kbmat, 64'd1 << 35);

    // break prefix, then a frame aborted by timeout returns decode to NORM
    send_ok(8'hF0);
    send_partial(5, H, c4);
    err_win = 1'b1;
    n_err = 0; t_err = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge mck);
      if (rx_err) begin n_err++; t_err = cyc; end
    end
    err_win = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    chk("t5_tmo_pulses", 64'(n_err), 64'd1);
    chk("t5_tmo_window", 64'(t_err >= c4 + TIMEOUT && t_err <= c4 + TIMEOUT + FILT + 4), 64'd1);
    send_ok(8'h5A);
    chk("t5_enter_make", kbmat, (64'd1 << 35) | (64'd1 << 6));

    // overrun clears everything; kb_clr beats a same-cycle strobe
    send_ok(8'h12); send_ok(8'h59);
    chk("t6_shifts", kbmat, (64'd1 << 35) | (64'd1 << 6) | (64'd1 << 54) | (64'd1 << 63));
    send_ok(8'hFF);
    chk("t6_overrun", kbmat, 64'd0);
    send_ok(8'h1C);
    send_frame(8'h1B, 1'b0, H, 1'b0, 1'b1);
    chk("t6_clr_strobe", kbmat, 64'd0);

    // shared bit: ENTER and KP-ENTER both drive bit 6
    send_ok(8'h5A); send_ok(8'hE0); send_ok(8'h5A);
    send_ok(8'hF0); send_ok(8'h5A);
    chk("shared_bit_held", kbmat, 64'd1 << 6);
    send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h5A);
    chk("shared_bit_clear", kbmat, 64'd0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        pulse_clr();
      end else begin
        q.delete();
        if (r < 72) begin
          k = $urandom_range(0, 15);
          ext = km_key[k][8]; code = km_key[k][7:0];
        end else if (r < 88) begin
          ext = 1'($urandom_range(0, 1)); code = 8'($urandom_range(1, 127));
        end else begin
          q.push_back(specials[$urandom_range(0, 8)]);
        end
        if (q.size() == 0) begin
          brk = 1'($urandom_range(0, 1));
          if (ext) q.push_back(8'hE0);
          if (brk) q.push_back(8'hF0);
          q.push_back(code);
        end
        foreach (q[i])
          send_frame(q[i], $urandom_range(0, 15) == 0, H, $urandom_range(0, 3) == 0, 1'b0);
      end
    end

    // async reset in the middle of a frame
    send_ok(8'hFF);
    send_ok(8'h1C);
    send_partial(4, H, c4);
    @(negedge mck);
    rin_n = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("rst_mid_kbmat", kbmat, 64'd0);
    chk("rst_mid_key_evt", 64'(key_evt), 64'd0);
    chk("rst_mid_rx_err", 64'(rx_err), 64'd0);
    clear_held();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    pm_v = 1'b0; pe_v = 1'b0; exp_mat = '0;
    wait_n(5);
    rin_n = 1'b1;
    wait_n(2);
    chk_en = 1'b1;
    send_ok(8'h1B);
    chk("rst_after_s_make", kbmat, 64'd1 << 35);

    wait_n(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
